// File: rtl/hazard_unit_multistage.sv
// ============================================================================
// Module   : hazard_unit_multistage
// Purpose  : Multi-stage operand forwarding, load-use stall with memory
//            handshake and timeout watchdog, multi-cycle flush sequencing and
//            a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit_multistage #(
  parameter int NUM_STAGES   = 2,
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int LOAD_TIMEOUT = 64,
  parameter int PERF_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REG_AW-1:0]            raddr1_i,
  input  logic [REG_AW-1:0]            raddr2_i,
  input  logic                         rs1_used_i,
  input  logic                         rs2_used_i,
  input  logic [NUM_STAGES*REG_AW-1:0] stage_rd_i,
  input  logic [NUM_STAGES-1:0]        stage_reg_wr_i,
  input  logic [NUM_STAGES-1:0]        stage_fwd_ok_i,
  input  logic [NUM_STAGES-1:0]        stage_is_load_i,
  input  logic                         mem_rvalid_i,
  input  logic                         pc_sel_i,
  input  logic                         epc_taken_i,
  output logic [NUM_STAGES-1:0]        forw_a_o,
  output logic [NUM_STAGES-1:0]        forw_b_o,
  output logic                         load_fwd_a_o,
  output logic                         load_fwd_b_o,
  output logic                         stall_o,
  output logic                         flush_o,
  output logic                         mem_timeout_o,
  output logic [PERF_W-1:0]            stall_count_o
);

  localparam int WCNT_W = $clog2(LOAD_TIMEOUT + 1);
  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [WCNT_W-1:0] c_wait_max     = WCNT_W'(LOAD_TIMEOUT);
  localparam logic [FCNT_W-1:0] c_flush_reload = FCNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [FCNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [PERF_W-1:0]   stall_count_q, stall_count_d;
  logic                timeout_q, timeout_d;

  logic [REG_AW-1:0]     w_raddr    [2];
  logic                  w_used     [2];
  logic [NUM_STAGES-1:0] w_fwd_sel  [2];
  logic [1:0]            w_hazard;
  logic [1:0]            w_load_haz;
  logic [1:0]            w_load_fwd;
  logic                  w_redirect;
  logic                  w_bypass_off;

  assign w_raddr[0] = raddr1_i;
  assign w_raddr[1] = raddr2_i;
  assign w_used[0]  = rs1_used_i;
  assign w_used[1]  = rs2_used_i;

  // One identical matcher per source operand (0 = rs1, 1 = rs2).
  for (genvar j = 0; j < 2; j++) begin : g_opnd
    logic [NUM_STAGES-1:0] w_sel;
    logic                  w_found;
    logic                  w_ok;
    logic                  w_ld;

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      w_ok    = 1'b0;
      w_ld    = 1'b0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
        if (w_used[j] && stage_reg_wr_i[i] &&
            (stage_rd_i[i*REG_AW +: REG_AW] != '0) &&
            (stage_rd_i[i*REG_AW +: REG_AW] == w_raddr[j])) begin
          w_sel    = '0;
          w_sel[i] = 1'b1;
          w_found  = 1'b1;
          w_ok     = stage_fwd_ok_i[i];
          w_ld     = stage_is_load_i[i];
        end
      end
    end

    assign w_hazard[j]   = w_found & ~w_ok & ~(w_ld & mem_rvalid_i);
    assign w_load_fwd[j] = w_found & ~w_ok & w_ld & mem_rvalid_i;
    assign w_load_haz[j] = w_hazard[j] & w_ld;
    assign w_fwd_sel[j]  = w_ok ? w_sel : '0;
  end

  // A watchdog expiry behaves like a redirect one cycle later.
  assign w_redirect   = pc_sel_i | epc_taken_i | timeout_q;
  assign flush_o      = ~rst & (w_redirect | (flush_cnt_q != '0));
  assign stall_o      = ~rst & (|w_hazard) & ~flush_o;
  assign w_bypass_off = stall_o | flush_o;

  assign forw_a_o      = w_bypass_off ? '0 : w_fwd_sel[0];
  assign forw_b_o      = w_bypass_off ? '0 : w_fwd_sel[1];
  assign load_fwd_a_o  = ~w_bypass_off & w_load_fwd[0];
  assign load_fwd_b_o  = ~w_bypass_off & w_load_fwd[1];
  assign stall_count_o = stall_count_q;

  // Load-wait FSM: track consecutive load stalls and fire the watchdog.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_d     = 1'b0;
    mem_timeout_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stall_o && (|w_load_haz)) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (flush_o || !stall_o) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == c_wait_max) begin
          mem_timeout_o = 1'b1;
          timeout_d     = 1'b1;
          state_d       = ST_IDLE;
          wait_cnt_d    = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Flush length counter and saturating stall counter next-state.
  always_comb begin
    flush_cnt_d   = flush_cnt_q;
    stall_count_d = stall_count_q;
    if (w_redirect) begin
      flush_cnt_d = c_flush_reload;
    end else if (flush_cnt_q != '0) begin
      flush_cnt_d = flush_cnt_q - FCNT_W'(1);
    end
    if (stall_o && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + PERF_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      flush_cnt_q   <= '0;
      stall_count_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      stall_count_q <= stall_count_d;
      timeout_q     <= timeout_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit_multistage.sv
// ============================================================================
// Module   : tb_hazard_unit_multistage
// Purpose  : Directed self-checking bench for hazard_unit_multistage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_unit_multistage;

  localparam int NS = 2;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic [AW-1:0] raddr1, raddr2;
  logic          rs1_used, rs2_used;
  logic [NS*AW-1:0] stage_rd;
  logic [NS-1:0] stage_reg_wr, stage_fwd_ok, stage_is_load;
  logic          mem_rvalid, pc_sel, epc_taken;
  logic [NS-1:0] forw_a, forw_b;
  logic          load_fwd_a, load_fwd_b, stall, flush, mem_timeout;
  logic [3:0]    stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_unit_multistage #(
    .NUM_STAGES  (NS),
    .REG_AW      (AW),
    .FLUSH_CYCLES(3),
    .LOAD_TIMEOUT(4),
    .PERF_W      (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .raddr1_i       (raddr1),
    .raddr2_i       (raddr2),
    .rs1_used_i     (rs1_used),
    .rs2_used_i     (rs2_used),
    .stage_rd_i     (stage_rd),
    .stage_reg_wr_i (stage_reg_wr),
    .stage_fwd_ok_i (stage_fwd_ok),
    .stage_is_load_i(stage_is_load),
    .mem_rvalid_i   (mem_rvalid),
    .pc_sel_i       (pc_sel),
    .epc_taken_i    (epc_taken),
    .forw_a_o       (forw_a),
    .forw_b_o       (forw_b),
    .load_fwd_a_o   (load_fwd_a),
    .load_fwd_b_o   (load_fwd_b),
    .stall_o        (stall),
    .flush_o        (flush),
    .mem_timeout_o  (mem_timeout),
    .stall_count_o  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic             u1;
    logic             u2;
    logic [NS*AW-1:0] rd;
    logic [NS-1:0]    wr;
    logic [NS-1:0]    ok;
    logic [NS-1:0]    ld;
    logic             rv;
    logic             pcs;
    logic             epc;
    logic [7:0]       exp;   // {forw_a, forw_b, load_fwd_a, load_fwd_b, stall, flush}
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    raddr1 = '0; raddr2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    stage_rd = '0; stage_reg_wr = '0; stage_fwd_ok = '0; stage_is_load = '0;
    mem_rvalid = 1'b0; pc_sel = 1'b0; epc_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Load hazard on rs2 = x7 from stage 1.
  task automatic set_load_hazard();
    clear_inputs();
    raddr2 = 5'd7; rs2_used = 1'b1;
    stage_rd = {5'd7, 5'd0}; stage_reg_wr = 2'b10; stage_is_load = 2'b10;
  endtask

  // Non-load hazard on rs2 = x7 from stage 0.
  task automatic set_alu_hazard();
    clear_inputs();
    raddr2 = 5'd7; rs2_used = 1'b1;
    stage_rd = {5'd0, 5'd7}; stage_reg_wr = 2'b01;
  endtask

  function automatic logic [7:0] outs();
    return {forw_a, forw_b, load_fwd_a, load_fwd_b, stall, flush};
  endfunction

  initial begin
    //            ra1    ra2    u1 u2  rd               wr     ok     ld     rv pcs epc  exp
    vecs[0]  = '{5'd5, 5'd0, 1, 0, {5'd5, 5'd5}, 2'b11, 2'b11, 2'b00, 0, 0, 0, 8'b01_00_0000};
    vecs[1]  = '{5'd5, 5'd0, 1, 0, {5'd5, 5'd3}, 2'b11, 2'b10, 2'b00, 0, 0, 0, 8'b10_00_0000};
    vecs[2]  = '{5'd0, 5'd7, 0, 1, {5'd0, 5'd7}, 2'b01, 2'b00, 2'b00, 0, 0, 0, 8'b00_00_0010};
    vecs[3]  = '{5'd0, 5'd7, 0, 1, {5'd7, 5'd0}, 2'b10, 2'b00, 2'b10, 1, 0, 0, 8'b00_00_0100};
    vecs[4]  = '{5'd0, 5'd0, 1, 0, {5'd0, 5'd0}, 2'b01, 2'b00, 2'b00, 0, 0, 0, 8'b00_00_0000};
    vecs[5]  = '{5'd9, 5'd0, 0, 0, {5'd0, 5'd9}, 2'b01, 2'b00, 2'b00, 0, 0, 0, 8'b00_00_0000};
    vecs[6]  = '{5'd9, 5'd0, 1, 0, {5'd0, 5'd9}, 2'b00, 2'b00, 2'b00, 0, 0, 0, 8'b00_00_0000};
    vecs[7]  = '{5'd5, 5'd0, 1, 0, {5'd5, 5'd5}, 2'b11, 2'b10, 2'b00, 0, 0, 0, 8'b00_00_0010};
    vecs[8]  = '{5'd5, 5'd0, 1, 0, {5'd5, 5'd5}, 2'b11, 2'b10, 2'b00, 0, 1, 0, 8'b00_00_0001};
    vecs[9]  = '{5'd5, 5'd6, 1, 1, {5'd6, 5'd5}, 2'b11, 2'b11, 2'b00, 0, 0, 0, 8'b01_10_0000};
    vecs[10] = '{5'd5, 5'd0, 1, 0, {5'd0, 5'd5}, 2'b01, 2'b01, 2'b00, 0, 0, 1, 8'b00_00_0001};
    vecs[11] = '{5'd4, 5'd0, 1, 0, {5'd4, 5'd0}, 2'b10, 2'b00, 2'b10, 0, 0, 0, 8'b00_00_0010};

    clear_inputs();
    rst = 1'b1;
    // Outputs forced quiet while reset is held, even with a redirect present.
    pc_sel = 1'b1;
    set_alu_hazard();
    pc_sel = 1'b1;
    @(negedge clk);
    check("rst_stall_flush", {stall, flush}, 2'b00);
    do_reset();
    @(negedge clk);
    check("reset_state", {outs(), mem_timeout, stall_count}, {8'h00, 1'b0, 4'd0});

    // Combinational vector table, each from a clean reset.
    for (int k = 0; k < 12; k++) begin
      do_reset();
      raddr1 = vecs[k].ra1; raddr2 = vecs[k].ra2;
      rs1_used = vecs[k].u1; rs2_used = vecs[k].u2;
      stage_rd = vecs[k].rd; stage_reg_wr = vecs[k].wr;
      stage_fwd_ok = vecs[k].ok; stage_is_load = vecs[k].ld;
      mem_rvalid = vecs[k].rv; pc_sel = vecs[k].pcs; epc_taken = vecs[k].epc;
      @(negedge clk);
      check($sformatf("vec%0d", k), outs(), vecs[k].exp);
    end

    // Load returns after three stalled cycles.
    do_reset();
    set_load_hazard();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("load_wait_stall_c%0d", c), {stall, load_fwd_b}, 2'b10);
      tick();
    end
    mem_rvalid = 1'b1;
    @(negedge clk);
    check("load_return", {stall, load_fwd_b, forw_b}, {1'b0, 1'b1, 2'b00});
    check("load_return_count", stall_count, 4'd3);
    tick();

    // Load never returns: watchdog fires after the 4th stalled cycle.
    do_reset();
    set_load_hazard();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("to_pre_c%0d", c), {stall, mem_timeout}, 2'b10);
      tick();
    end
    @(negedge clk);
    check("to_pulse", {mem_timeout, flush}, 2'b10);
    check("to_pulse_count", stall_count, 4'd4);
    tick();
    @(negedge clk);
    check("to_flush", {mem_timeout, flush, stall}, 3'b010);
    check("to_flush_count", stall_count, 4'd5);
    tick(); tick();
    @(negedge clk);
    check("to_flush_last", flush, 1'b1);
    tick();
    @(negedge clk);
    check("to_flush_done", {flush, stall}, 2'b01);

    // Overlapping redirects with an ALU hazard present.
    do_reset();
    set_alu_hazard();
    pc_sel = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("flush_c%0d", c), {flush, stall}, 2'b10);
      tick();
      pc_sel = 1'b0;
      epc_taken = (c == 0);
    end
    @(negedge clk);
    check("flush_end", {flush, stall, stall_count}, {2'b01, 4'd0});

    // Reset in the middle of a load wait aborts it.
    do_reset();
    set_load_hazard();
    tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_wait_outs", {stall, flush, mem_timeout}, 3'b000);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_wait_count", {stall, stall_count}, {1'b1, 4'd0});
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("rst_wait_no_to_c%0d", c), mem_timeout, 1'b0);
      tick();
    end
    @(negedge clk);
    check("rst_wait_to", mem_timeout, 1'b1);

    // Stall counter saturates.
    do_reset();
    set_alu_hazard();
    for (int c = 0; c < 21; c++) tick();
    @(negedge clk);
    check("sat_count", {stall, stall_count}, {1'b1, 4'hF});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
